// File: rtl/sram_arbiter.sv
// Purpose : round-robin arbiter sharing one byte-wide SRAM bus between two masters (m0 CPU, m1 loader/DMA).
// Latency : cs high for 1+WAIT_STATES cycles after the grant edge; ack one cycle later; next grant WAIT_STATES+3 cycles on.
// Backpressure: a master holds req/addr/we/wdata until its ack; one access in flight, the other master simply waits.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   m0_req/we/addr/wdata          master 0 request (held until m0_ack)
//   m0_rdata, m0_ack              master 0 read data (held) and one-cycle completion pulse
//   m1_*                          identical set for master 1
//   A, data_out, data_in, cs, we  SRAM bus (cs/we active-high)
//   busy, grant_id                access in progress (ACCESS/DONE) and owning master
module sram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    output logic              cs,
    output logic              we,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       last_grant;
    logic       pick;

    // On a tie the master that did not win last time gets the bus;
    // otherwise whichever master is requesting (m1 iff only m1 asks).
    assign pick = (m0_req && m1_req) ? ~last_grant : m1_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            last_grant <= 1'b1;
            cs         <= 1'b0;
            we         <= 1'b0;
            A          <= '0;
            data_out   <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        A          <= pick ? m1_addr  : m0_addr;
                        we         <= pick ? m1_we    : m0_we;
                        data_out   <= pick ? m1_wdata : m0_wdata;
                        cs         <= 1'b1;
                        grant_id   <= pick;
                        last_grant <= pick;
                        wait_cnt   <= WAIT_INIT;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        // Read data is captured on the edge that ends the last cs cycle.
                        if (!we) begin
                            if (grant_id) m1_rdata <= data_in;
                            else          m0_rdata <= data_in;
                        end
                        if (grant_id) m1_ack <= 1'b1;
                        else          m0_ack <= 1'b1;
                        cs    <= 1'b0;
                        we    <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Turnaround cycle: ack is visible now, bus idle before the next grant.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose : checks two sram_arbiter instances (WAIT_STATES=1 and 3) driven by identical stimulus.
// Latency : expected bus activity derived from the grant cycle with plain arithmetic.
// Backpressure: bench masters hold requests until they see the WAIT_STATES=1 instance ack.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata, data_in;

    logic [1:0][7:0]  m0_rdata_o, m1_rdata_o, dout_o;
    logic [1:0][15:0] a_o;
    logic [1:0]       m0_ack_o, m1_ack_o, cs_o, we_o, busy_o, gid_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model, one set per instance
    int          t_start [2];
    int          free_at [2];
    bit          t_owner [2];
    bit          t_we    [2];
    logic [15:0] t_addr  [2];
    logic [7:0]  t_wdata [2];
    bit          last_g  [2];
    logic [7:0]  exp_rd  [2][2];
    bit          rst_prev;

    sram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(1)) u_dut_ws1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata_o[0]), .m0_ack(m0_ack_o[0]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata_o[0]), .m1_ack(m1_ack_o[0]),
        .A(a_o[0]), .data_out(dout_o[0]), .data_in(data_in),
        .cs(cs_o[0]), .we(we_o[0]), .busy(busy_o[0]), .grant_id(gid_o[0])
    );

    sram_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata_o[1]), .m0_ack(m0_ack_o[1]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata_o[1]), .m1_ack(m1_ack_o[1]),
        .A(a_o[1]), .data_out(dout_o[1]), .data_in(data_in),
        .cs(cs_o[1]), .we(we_o[1]), .busy(busy_o[1]), .grant_id(gid_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s ws%0d cyc=%0d observed=%h expected=%h", tag, ws(d), cyc, obs, exp);
        end
    endtask

    // Apply the arbitration rules to the inputs present during cycle cyc.
    task automatic model_edge(input int d);
        bit owner;
        if (rst) begin
            t_start[d]   = -1000;
            free_at[d]   = cyc + 1;
            last_g[d]    = 1'b1;
            exp_rd[d][0] = '0;
            exp_rd[d][1] = '0;
        end else begin
            if (cyc == t_start[d] + 1 + ws(d) && !t_we[d])
                exp_rd[d][t_owner[d]] = data_in;
            if (cyc >= free_at[d] && (m0_req || m1_req)) begin
                owner      = (m0_req && m1_req) ? !last_g[d] : m1_req;
                t_owner[d] = owner;
                t_we[d]    = owner ? m1_we    : m0_we;
                t_addr[d]  = owner ? m1_addr  : m0_addr;
                t_wdata[d] = owner ? m1_wdata : m0_wdata;
                t_start[d] = cyc;
                free_at[d] = cyc + 3 + ws(d);
                last_g[d]  = owner;
            end
        end
    endtask

    task automatic check_outputs(input int d);
        bit in_cs, ack_c, bsy;
        if (rst_prev) begin
            chk("rst_cs",   d, cs_o[d],       0);
            chk("rst_we",   d, we_o[d],       0);
            chk("rst_A",    d, a_o[d],        0);
            chk("rst_dout", d, dout_o[d],     0);
            chk("rst_ack0", d, m0_ack_o[d],   0);
            chk("rst_ack1", d, m1_ack_o[d],   0);
            chk("rst_busy", d, busy_o[d],     0);
            chk("rst_gid",  d, gid_o[d],      0);
            chk("rst_rd0",  d, m0_rdata_o[d], 0);
            chk("rst_rd1",  d, m1_rdata_o[d], 0);
        end else begin
            in_cs = (cyc >= t_start[d] + 1) && (cyc <= t_start[d] + 1 + ws(d));
            ack_c = (cyc == t_start[d] + 2 + ws(d));
            bsy   = in_cs || ack_c;
            chk("cs",   d, cs_o[d],     in_cs);
            chk("we",   d, we_o[d],     in_cs && t_we[d]);
            chk("busy", d, busy_o[d],   bsy);
            chk("ack0", d, m0_ack_o[d], ack_c && !t_owner[d]);
            chk("ack1", d, m1_ack_o[d], ack_c && t_owner[d]);
            if (in_cs) begin
                chk("A",    d, a_o[d],    t_addr[d]);
                chk("dout", d, dout_o[d], t_wdata[d]);
            end
            if (bsy) chk("gid", d, gid_o[d], t_owner[d]);
            chk("rd0", d, m0_rdata_o[d], exp_rd[d][0]);
            chk("rd1", d, m1_rdata_o[d], exp_rd[d][1]);
        end
    endtask

    task automatic tick();
        for (int d = 0; d < 2; d++) model_edge(d);
        rst_prev = rst;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) check_outputs(d);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_fields(output logic w, output logic [15:0] a, output logic [7:0] wd);
        w  = 1'($urandom);
        a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        wd = 8'($urandom);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            t_start[d] = -1000; free_at[d] = 0; last_g[d] = 1'b1;
            t_owner[d] = 1'b0; t_we[d] = 1'b0; t_addr[d] = '0; t_wdata[d] = '0;
            exp_rd[d][0] = '0; exp_rd[d][1] = '0;
        end
        rst_prev = 1'b0;

        // Reset held 3 cycles while every input toggles
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m0_req = 1'($urandom); m1_req = 1'($urandom); data_in = 8'($urandom);
            rand_fields(m0_we, m0_addr, m0_wdata);
            rand_fields(m1_we, m1_addr, m1_wdata);
            tick();
        end
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        ticks(2);

        // Master 0 read of 0x0010 returning 0xCC
        m0_addr = 16'h0010; m0_we = 1'b0; m0_wdata = 8'h00; data_in = 8'hCC; m0_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m0_ack_o[0]) m0_req = 1'b0;
        end
        chk("m0_read_cc", 0, m0_rdata_o[0], 8'hCC);
        chk("m0_read_cc", 1, m0_rdata_o[1], 8'hCC);

        // Master 1 write of 0x5A to 0x1234; its rdata must stay untouched
        m1_addr = 16'h1234; m1_wdata = 8'h5A; m1_we = 1'b1; data_in = 8'h77; m1_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m1_ack_o[0]) m1_req = 1'b0;
        end
        chk("m1_write_rdata", 0, m1_rdata_o[0], 8'h00);

        // Contention: both held, reads from 0x0001 / 0x0002, alternating grants
        m0_addr = 16'h0001; m0_we = 1'b0; m1_addr = 16'h0002; m1_we = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = 8'($urandom);
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        ticks(8);

        // Reset in the 2nd access cycle of the WAIT_STATES=3 instance, then a tie must go to m0
        m0_addr = 16'h00A0; m0_we = 1'b1; m0_wdata = 8'h3C; m0_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; m0_req = 1'b0;
        tick();
        m0_we = 1'b0; m0_addr = 16'h0B0B; m1_addr = 16'h0C0C; m1_we = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; data_in = 8'h96;
        tick();
        chk("post_rst_gid", 0, gid_o[0], 1'b0);
        chk("post_rst_gid", 1, gid_o[1], 1'b0);
        m0_req = 1'b0; m1_req = 1'b0;
        ticks(8);

        // Request dropped in the first access cycle still completes
        m0_addr = 16'hFFFF; m0_we = 1'b0; data_in = 8'h5E; m0_req = 1'b1;
        tick();
        tick();
        m0_req = 1'b0; m0_addr = 16'h1111;
        ticks(8);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            data_in = 8'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            if (m0_req && m0_ack_o[0]) begin
                m0_req = 1'($urandom);
                rand_fields(m0_we, m0_addr, m0_wdata);
            end else if (m0_req) begin
                if ($urandom_range(0, 15) == 0) m0_req = 1'b0;
                else if ($urandom_range(0, 3) == 0) rand_fields(m0_we, m0_addr, m0_wdata);
            end else if ($urandom_range(0, 2) == 0) begin
                m0_req = 1'b1;
                rand_fields(m0_we, m0_addr, m0_wdata);
            end
            if (m1_req && m1_ack_o[0]) begin
                m1_req = 1'($urandom);
                rand_fields(m1_we, m1_addr, m1_wdata);
            end else if (m1_req) begin
                if ($urandom_range(0, 15) == 0) m1_req = 1'b0;
                else if ($urandom_range(0, 3) == 0) rand_fields(m1_we, m1_addr, m1_wdata);
            end else if ($urandom_range(0, 2) == 0) begin
                m1_req = 1'b1;
                rand_fields(m1_we, m1_addr, m1_wdata);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external byte-wide SRAM bus (A, data_out, data_in, cs, we) between two requesters.
  - Master 0: the CPU data port (LOAD/STORE/FETCH traffic).
  - Master 1: the program loader / IO DMA.
- Round-robin arbitration, one access in flight at a time.
- Configurable SRAM wait states; req/ack handshake toward each master.

Parameters:
- ADDR_W, 16, SRAM address width (matches SRAM_BITWIDTH).
- DATA_W, 8, SRAM data width.
- WAIT_STATES, 1, extra cycles cs is held beyond the first (0..15).

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 access request; held until m0_ack.
- m0_we  in  1  master 0 write(1)/read(0).
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_rdata  out  DATA_W  master 0 read data, valid with m0_ack, held after.
- m0_ack  out  1  one-cycle completion pulse to master 0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as m0_*, for master 1.
- A  out  ADDR_W  SRAM address.
- data_out  out  DATA_W  SRAM write data.
- data_in  in  DATA_W  SRAM read data.
- cs  out  1  SRAM chip select, active-high.
- we  out  1  SRAM write enable, active-high, only while cs=1.
- busy  out  1  high in ACCESS and DONE.
- grant_id  out  1  master owning the bus; valid while busy.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE.
  - cs=0, we=0, A=0, data_out=0.
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0.
  - busy=0, grant_id=0, last_grant=1, so master 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay.
  - Exactly one req: grant that master.
  - Both reqs: grant the master != last_grant.
  - On grant, the same edge:
    - Latch addr→A, we→we, wdata→data_out.
    - Set cs=1, grant_id, last_grant=granted master, wait_cnt=WAIT_STATES.
    - Go to ACCESS.
- ACCESS:
  - cs and we held; A/data_out stable.
  - wait_cnt>0: decrement.
  - wait_cnt==0:
    - Sample data_in into the granted master's rdata (reads only; writes leave rdata unchanged).
    - Pulse the granted master's ack.
    - cs=0, we=0; go to DONE.
- DONE: ack high for exactly this cycle; unconditionally go to IDLE (bus turnaround).
- Timing (cycle 0 = IDLE cycle where req is sampled):
  - cs high for cycles 1..1+WAIT_STATES.
  - ack in cycle 2+WAIT_STATES.
  - Minimum request spacing is WAIT_STATES+3 cycles.
- Handshake rules:
  - The master holds req, addr, we and wdata until it sees ack.
  - If req is still high in the IDLE cycle after DONE, it is a new request; back-to-back traffic is legal.
  - Round-robin applies at that point: a continuously requesting master alternates with the other.
- Boundary cases:
  - Changes to addr/we/wdata during ACCESS are ignored (latched).
  - req dropped mid-access: the access still completes and ack still pulses; no retry.
  - rst during ACCESS or DONE: the next edge returns to IDLE with cs=0 and no ack; the aborted write may be partial in SRAM.
  - Only one ack is ever high at a time; the non-granted master's rdata and ack are untouched.
  - WAIT_STATES=0 gives a single-cycle cs.
  - Address 0xFFFF passes through unchanged; there is no wrap logic.

Test Plan:
- Reset: hold rst=1 for 3 cycles, toggle all inputs → cs=0, we=0, A=0, data_out=0, acks 0, rdata 0, busy=0.
- Master 0 read: WAIT_STATES=1, m0_addr=0x0010, m0_we=0, data_in=0xCC → cs=1 in cycles 1–2 with A=0x0010, we=0; m0_ack in cycle 3; m0_rdata=0xCC; m1_ack stays 0.
- Master 1 write: m1_addr=0x1234, m1_wdata=0x5A, m1_we=1 → cs=we=1 for 2 cycles with data_out=0x5A; m1_ack pulses; m1_rdata unchanged.
- Contention: m0_req and m1_req held high, m0_addr=0x0001, m1_addr=0x0002 → grant order m0, m1, m0, m1; one ack per 4 cycles; A alternates 0x0001/0x0002.
- Reset mid-access: WAIT_STATES=3, assert rst in the 2nd ACCESS cycle → cs=0 next cycle, no ack; the next request after reset release is granted to master 0.
- Dropped request: m0_req drops in the 1st ACCESS cycle → access completes, m0_ack pulses once, then IDLE with cs=0.
